// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI requester arbiter.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, RESPOND} state_e;

  localparam int SPI_MAX_BYTES       = 4;
  localparam int DEF_CS_SETUP_CYCLES = 4;
  localparam int DEF_CS_HOLD_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 4095;

  function automatic logic bytes_ok(input logic [2:0] b);
    return (b != 3'd0) && (int'(b) <= SPI_MAX_BYTES);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  always_comb begin
    logic [IW-1:0] k;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = '0;
    // Scan from farthest to nearest so the closest valid requester wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (valid_i[k]) begin
        idx_o = k;
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates NUM_REQ requesters onto one SPI master with CS setup/hold timing.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int CS_SETUP_CYCLES = DEF_CS_SETUP_CYCLES,
  parameter int CS_HOLD_CYCLES  = DEF_CS_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [32*NUM_REQ-1:0] req_wdata_i,
  input  logic [3*NUM_REQ-1:0] req_bytes_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NUM_REQ-1:0]   spi_cs_n_o,
  output logic                 spi_enable_o,
  output logic [31:0]          spi_wdata_o,
  output logic [2:0]           spi_bytes_o,
  input  logic                 spi_ready_i,
  input  logic [31:0]          spi_rdata_i,
  input  logic [2:0]           spi_bytes_valid_i
);
  localparam int IW     = $clog2(NUM_REQ);
  localparam int MAX_SH = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CNT_MX = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(CNT_MX + 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]          bytes_q, bytes_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  gnt_vec;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [2:0]          gnt_bytes;
  logic [NUM_REQ-1:0]  own_oh;
  logic                cs_act;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (gnt_vec),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign gnt_bytes = req_bytes_i[gnt_idx*3 +: 3];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    bytes_d     = bytes_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: if (spi_ready_i && gnt_any) begin
        req_ready_o = gnt_vec;
        idx_d       = gnt_idx;
        ptr_d       = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        wdata_d     = req_wdata_i[gnt_idx*32 +: 32];
        bytes_d     = gnt_bytes;
        rdata_d     = '0;
        cnt_d       = '0;
        // Malformed byte counts never touch the bus; answer with an error.
        err_d       = !bytes_ok(gnt_bytes);
        state_d     = bytes_ok(gnt_bytes) ? CS_SETUP : RESPOND;
      end
      CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CS_SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (spi_bytes_valid_i == bytes_q) begin
          rdata_d = spi_rdata_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = CS_HOLD;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = CS_HOLD;
        end
      end
      CS_HOLD: begin
        // Counter saturates at the hold length; CS releases there while we wait for the master.
        if (cnt_q < CW'(CS_HOLD_CYCLES)) cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CW'(CS_HOLD_CYCLES - 1) && spi_ready_i) begin
          cnt_d   = '0;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      bytes_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      bytes_q <= bytes_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign own_oh = NUM_REQ'(1) << idx_q;
  assign cs_act = (state_q == CS_SETUP) || (state_q == XFER) ||
                  ((state_q == CS_HOLD) && (cnt_q < CW'(CS_HOLD_CYCLES)));

  assign spi_cs_n_o   = cs_act ? ~own_oh : '1;
  assign spi_enable_o = (state_q == XFER);
  assign spi_wdata_o  = spi_enable_o ? wdata_q : '0;
  assign spi_bytes_o  = spi_enable_o ? bytes_q : '0;
  assign rsp_valid_o  = (state_q == RESPOND) ? own_oh : '0;
  assign rsp_rdata_o  = (state_q == RESPOND) ? rdata_q : '0;
  assign rsp_error_o  = (state_q == RESPOND) && err_q;
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter CS_SETUP_CYCLES, default 4, clk_i cycles from CS assert to SPI enable.
REQ-003 Parameter CS_HOLD_CYCLES, default 4, clk_i cycles from enable drop to CS release.
REQ-004 Parameter TIMEOUT_CYCLES, default 4095, max clk_i cycles in XFER before abort.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous and active-low.
REQ-007 req_valid_i  in  NUM_REQ  per-requester transaction request.
REQ-008 req_wdata_i  in  32*NUM_REQ  per-requester write word; slice k = bits [32k+31:32k].
REQ-009 req_bytes_i  in  3*NUM_REQ  per-requester byte count; slice k = bits [3k+2:3k].
REQ-010 req_ready_o  out  NUM_REQ  one-hot accept pulse; request taken when valid and ready both high.
REQ-011 rsp_valid_o  out  NUM_REQ  one-hot, one-cycle completion pulse to owning requester.
REQ-012 rsp_rdata_o  out  32  read word, right-aligned (last byte received in [7:0]), qualified by rsp_valid_o.
REQ-013 rsp_error_o  out  1  error flag, qualified by rsp_valid_o.
REQ-014 spi_cs_n_o  out  NUM_REQ  active-low chip selects, at most one low.
REQ-015 spi_enable_o  out  1  enable to SPI master.
REQ-016 spi_wdata_o  out  32  write word to SPI master, stable while enable high.
REQ-017 spi_bytes_o  out  3  byte count to SPI master, stable while enable high.
REQ-018 spi_ready_i  in  1  SPI master idle and fill level zero.
REQ-019 spi_rdata_i  in  32  SPI master read data.
REQ-020 spi_bytes_valid_i  in  3  SPI master received-byte count.

Function
REQ-021 States: IDLE, CS_SETUP, XFER, CS_HOLD, RESPOND; one transaction in flight at a time.
REQ-022 IDLE: if spi_ready_i high and any req_valid_i, grant round-robin winner (first valid at or after pointer, wrapping), pulse its req_ready_o one cycle, latch wdata/bytes/index.
REQ-023 Pointer resets to 0; on each grant becomes winner+1, wrapping NUM_REQ-1 -> 0.
REQ-024 Latched bytes of 0 or >4: no CS, no enable; go directly to RESPOND with rsp_error_o=1, rsp_rdata_o=0.
REQ-025 Valid grant: next cycle drive winner's spi_cs_n_o low, enter CS_SETUP, count CS_SETUP_CYCLES cycles.
REQ-026 XFER: spi_enable_o high, spi_wdata_o/spi_bytes_o from latch; leave when spi_bytes_valid_i equals latched bytes, capturing spi_rdata_i that cycle.
REQ-027 XFER timeout: after TIMEOUT_CYCLES cycles without completion, drop enable, set error, rdata 0, go CS_HOLD.
REQ-028 CS_HOLD: enable low, CS held CS_HOLD_CYCLES cycles then released; advance to RESPOND only once spi_ready_i is high.
REQ-029 RESPOND: one-cycle rsp_valid_o pulse to owner, then IDLE; next grant no earlier than cycle after RESPOND.
REQ-030 req_valid_i deassert after acceptance has no effect; requests not sampled outside IDLE.
REQ-031 Simultaneous requests: exactly one granted per IDLE decision; others remain pending.
REQ-032 spi_wdata_o/spi_bytes_o zero whenever spi_enable_o low.

Reset
REQ-033 rstn_i low: immediately state IDLE, pointer 0, spi_cs_n_o all 1, spi_enable_o 0, req_ready_o 0, rsp_valid_o 0, rsp_error_o 0, rsp_rdata_o 0, spi_wdata_o 0, spi_bytes_o 0, counters 0.
REQ-034 Reset mid-transaction aborts without response; CS released asynchronously.

Structure
REQ-035 Shared package spi_pkg: state encoding, SPI_MAX_BYTES=4, default timing constants.
REQ-036 One sub-module rr_arbiter (valid vector, pointer -> one-hot grant, index).

Verification
REQ-037 Req0 only, bytes=2, wdata 0x0000A55A, master returns 0x00003CC3 -> cs_n[0] low, enable after 4 cycles, rsp_valid[0] with rdata 0x00003CC3, error 0.
REQ-038 All four valid at once, from reset -> grants 0,1,2,3 in order, no CS overlap, each rsp_valid pulses once.
REQ-039 Req2 bytes=0, then bytes=5 -> no CS/enable, rsp_valid[2] with error 1 each time.
REQ-040 Master never reaches bytes valid -> enable drops after 4095 cycles, CS held 4 more, rsp error 1, rdata 0.
REQ-041 rstn_i low during XFER -> same cycle cs_n all 1, enable 0, no rsp_valid; next request served normally from pointer 0.
REQ-042 Req1 granted while req0 continuously valid -> next grant is req0 only after req2/req3 skipped as not valid (wrap).
